// File: rtl/dual_slope_adc_ctrl.sv
// Dual-slope ADC sequencer: auto-zero/integrate/de-integrate control, BCD de-integrate count and multiplexed digit scan.
// Optional build macro LZB_EN blanks leading zero digits in the scanned output.
module dual_slope_adc_ctrl #(
    parameter int NDIG     = 3,
    parameter int AZ_CNT   = 4000,
    parameter int INT_CNT  = 4000,
    parameter int UR_LIM   = 180,
    parameter int SCAN_DIV = 80
) (
    input  logic              CP0,
    input  logic              R8,
    input  logic              START,
    input  logic              CMP,
    input  logic              POL_IN,
    input  logic              DU,
    output logic              PH_AZ,
    output logic              PH_INT,
    output logic              PH_DE,
    output logic              EOC,
    output logic [4*NDIG-1:0] BCD,
    output logic              HALF,
    output logic              POL,
    output logic              OR,
    output logic              UR,
    output logic [NDIG:0]     DS,
    output logic [3:0]        Q
);

    localparam int PH_MAX = (AZ_CNT > INT_CNT) ? AZ_CNT : INT_CNT;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PH_W-1:0]   AZ_LAST  = PH_W'(AZ_CNT - 1);
    localparam logic [PH_W-1:0]   INT_LAST = PH_W'(INT_CNT - 1);
    localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [4*NDIG:0]   CNT_MAX  = {1'b1, {NDIG{4'h9}}};

    typedef enum logic [2:0] {IDLE, AZ, INT, DE, LATCH} state_t;

    state_t            state;
    logic [PH_W-1:0]   ph_cnt;
    logic [4*NDIG:0]   cnt;      // {half digit, full BCD digits}
    logic              ovr;
    logic              sign;
    logic              cmp_q;
    logic [SC_W-1:0]   scan_cnt;
    logic              load;

    function automatic logic [4*NDIG:0] bcd_inc(input logic [4*NDIG:0] v);
        logic [4*NDIG:0] r;
        logic            c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        if (c) r[4*NDIG] = 1'b1;
        return r;
    endfunction

    function automatic int bcd_val(input logic [4*NDIG:0] v);
        int acc;
        int p;
        acc = 0;
        p   = 1;
        for (int i = 0; i < NDIG; i++) begin
            acc = acc + int'(v[4*i +: 4]) * p;
            p   = p * 10;
        end
        acc = acc + int'(v[4*NDIG]) * p;
        return acc;
    endfunction

    function automatic logic [3:0] digit_sel(input logic [4*NDIG-1:0] b, input int i);
        logic [4*NDIG-1:0] hi;
        hi = b >> (4*i);
        digit_sel = hi[3:0];
`ifdef LZB_EN
        if (i > 0 && hi == '0) digit_sel = 4'hF;
`endif
    endfunction

    assign load = (state == LATCH) && DU;

    always_ff @(posedge CP0) begin
        if (R8) begin
            state  <= IDLE;
            ph_cnt <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
            sign   <= 1'b0;
            cmp_q  <= 1'b0;
            PH_AZ  <= 1'b0;
            PH_INT <= 1'b0;
            PH_DE  <= 1'b0;
            EOC    <= 1'b0;
            BCD    <= '0;
            HALF   <= 1'b0;
            POL    <= 1'b0;
            OR     <= 1'b0;
            UR     <= 1'b0;
        end else begin
            cmp_q <= CMP;
            EOC   <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state  <= AZ;
                        ph_cnt <= '0;
                        PH_AZ  <= 1'b1;
                    end
                end
                AZ: begin
                    if (ph_cnt == AZ_LAST) begin
                        state  <= INT;
                        ph_cnt <= '0;
                        PH_AZ  <= 1'b0;
                        PH_INT <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                INT: begin
                    if (ph_cnt == INT_LAST) begin
                        state  <= DE;
                        ph_cnt <= '0;
                        cnt    <= '0;
                        ovr    <= 1'b0;
                        sign   <= POL_IN;
                        PH_INT <= 1'b0;
                        PH_DE  <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                DE: begin
                    // cmp_q lags CMP by one edge, so the count includes that extra cycle
                    if (!cmp_q) begin
                        state <= LATCH;
                        PH_DE <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= LATCH;
                        ovr   <= 1'b1;
                        PH_DE <= 1'b0;
                    end else begin
                        cnt <= bcd_inc(cnt);
                    end
                end
                LATCH: begin
                    if (load) begin
                        {HALF, BCD} <= cnt;
                        POL <= sign;
                        OR  <= ovr;
                        UR  <= !ovr && (bcd_val(cnt) < UR_LIM);
                        EOC <= 1'b1;
                    end
                    if (START) begin
                        state  <= AZ;
                        ph_cnt <= '0;
                        PH_AZ  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scanning starts with the first loaded result and then free-runs
    always_ff @(posedge CP0) begin
        if (R8) begin
            DS       <= '0;
            scan_cnt <= '0;
        end else if (DS == '0) begin
            if (load) begin
                DS       <= {{NDIG{1'b0}}, 1'b1};
                scan_cnt <= '0;
            end
        end else if (scan_cnt == SC_LAST) begin
            scan_cnt <= '0;
            DS       <= {DS[NDIG-1:0], DS[NDIG]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        Q = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (DS[i]) Q = digit_sel(BCD, i);
        end
        if (DS[NDIG]) Q = {POL, HALF, OR, UR};
    end

endmodule
